turret_fire_ctrl: RTL and testbench

Frame-synchronous controller that owns the player turret angle and the single player bullet. It turns raw keyboard keycodes into debounced turret rotation steps and sequences one bullet through launch, flight, and cooldown. It runs on the system clock with a per-frame tick, and it replaces keycode-derived clocking for the turret angle register. It drives the turret sprite select, plus the motion vector and active flag consumed by the bullet motion/drawing logic.

---
 rtl/turret_fire_ctrl.sv | 178 +++++++++++++++++
 tb/tb_turret_fire_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turret_fire_ctrl.sv
// Turret angle and single-bullet fire sequencer, stepped by the per-frame tick.
// Optional held-key auto-repeat rotation is compiled in with `define TURRET_AUTOREPEAT_EN.
module turret_fire_ctrl #(
    parameter int BULLET_LIFE = 120,
    parameter int COOLDOWN    = 30,
    parameter int STEP_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       hit,
    output logic [3:0] angle_idx,
    output logic [8:0] angle_onehot,
    output logic [9:0] aim_dx,
    output logic [9:0] aim_dy,
    output logic [9:0] bullet_dx,
    output logic [9:0] bullet_dy,
    output logic       bullet_active,
    output logic       launch,
    output logic       busy
);

    localparam logic [7:0] KEY_UP   = 8'h1A;
    localparam logic [7:0] KEY_DOWN = 8'h16;
    localparam logic [7:0] KEY_FIRE = 8'h2C;
    localparam logic [3:0] ANGLE_MAX   = 4'd8;
    localparam logic [3:0] ANGLE_RESET = 4'd4;

    typedef enum logic [1:0] {IDLE, FLY, COOL} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  life_reg, life_next;
    logic [7:0]  cool_reg, cool_next;
    logic [7:0]  prev_key_reg;
    logic [3:0]  angle_reg, angle_next;
    logic [9:0]  bullet_dx_reg, bullet_dy_reg;
    logic        launch_reg, launch_next;

    logic up_press, down_press, fire_press;
    logic step_up, step_down;

    always_comb begin
        up_press   = frame_tick && (keycode == KEY_UP)   && (prev_key_reg != KEY_UP);
        down_press = frame_tick && (keycode == KEY_DOWN) && (prev_key_reg != KEY_DOWN);
        fire_press = frame_tick && (keycode == KEY_FIRE) && (prev_key_reg != KEY_FIRE);
    end

`ifdef TURRET_AUTOREPEAT_EN
    // Counts ticks a rotate key has been held since its press or last repeat step.
    logic [7:0] rep_cnt_reg, rep_cnt_next;
    logic       up_hold, down_hold, rep_due;

    always_comb begin
        up_hold   = frame_tick && (keycode == KEY_UP)   && (prev_key_reg == KEY_UP);
        down_hold = frame_tick && (keycode == KEY_DOWN) && (prev_key_reg == KEY_DOWN);
        rep_due   = (rep_cnt_reg == 8'(STEP_FRAMES - 1));
        step_up   = up_press   || (up_hold   && rep_due);
        step_down = down_press || (down_hold && rep_due);
        rep_cnt_next = rep_cnt_reg;
        if (frame_tick) begin
            if (up_press || down_press)
                rep_cnt_next = 8'd0;
            else if (up_hold || down_hold)
                rep_cnt_next = rep_due ? 8'd0 : rep_cnt_reg + 8'd1;
            else
                rep_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            rep_cnt_reg <= 8'd0;
        else
            rep_cnt_reg <= rep_cnt_next;
    end
`else
    always_comb begin
        step_up   = up_press;
        step_down = down_press;
    end
`endif

    always_comb begin
        angle_next = angle_reg;
        if (step_up && (angle_reg < ANGLE_MAX))
            angle_next = angle_reg + 4'd1;
        else if (step_down && (angle_reg != 4'd0))
            angle_next = angle_reg - 4'd1;
    end

    // State register, including the datapath registers updated alongside it.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            life_reg      <= 8'd0;
            cool_reg      <= 8'd0;
            prev_key_reg  <= 8'd0;
            angle_reg     <= ANGLE_RESET;
            bullet_dx_reg <= 10'd0;
            bullet_dy_reg <= 10'd0;
            launch_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            life_reg   <= life_next;
            cool_reg   <= cool_next;
            angle_reg  <= angle_next;
            launch_reg <= launch_next;
            if (frame_tick)
                prev_key_reg <= keycode;
            if (launch_next) begin
                bullet_dx_reg <= aim_dx;
                bullet_dy_reg <= aim_dy;
            end
        end
    end

    // Next-state logic; a hit on the expiring tick still yields one transition.
    always_comb begin
        state_next  = state_reg;
        life_next   = life_reg;
        cool_next   = cool_reg;
        launch_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fire_press) begin
                    state_next  = FLY;
                    launch_next = 1'b1;
                    life_next   = 8'(BULLET_LIFE);
                end
            end
            FLY: begin
                if (frame_tick)
                    life_next = life_reg - 8'd1;
                if (hit || (frame_tick && (life_reg == 8'd1))) begin
                    cool_next  = 8'(COOLDOWN);
                    state_next = (COOLDOWN == 0) ? IDLE : COOL;
                end
            end
            COOL: begin
                if (frame_tick) begin
                    cool_next = cool_reg - 8'd1;
                    if (cool_reg == 8'd1)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode; out-of-range indices fall back to the horizontal aim.
    always_comb begin
        angle_idx     = angle_reg;
        bullet_dx     = bullet_dx_reg;
        bullet_dy     = bullet_dy_reg;
        launch        = launch_reg;
        bullet_active = (state_reg == FLY);
        busy          = (state_reg != IDLE);
        case (angle_reg)
            4'd0:    begin aim_dx = 10'd0; aim_dy = 10'd1;     end
            4'd1:    begin aim_dx = 10'd1; aim_dy = 10'd2;     end
            4'd2:    begin aim_dx = 10'd1; aim_dy = 10'd1;     end
            4'd3:    begin aim_dx = 10'd2; aim_dy = 10'd1;     end
            4'd5:    begin aim_dx = 10'd2; aim_dy = 10'h3FF;   end
            4'd6:    begin aim_dx = 10'd1; aim_dy = 10'h3FF;   end
            4'd7:    begin aim_dx = 10'd1; aim_dy = 10'h3FE;   end
            4'd8:    begin aim_dx = 10'd0; aim_dy = 10'h3FF;   end
            default: begin aim_dx = 10'd1; aim_dy = 10'd0;     end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_onehot
            assign angle_onehot[gi] = (angle_reg == 4'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_turret_fire_ctrl.sv
// Directed bench for turret_fire_ctrl: rotation, launch, flight, cooldown, hit and reset.
module tb_turret_fire_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] keycode = 8'd0;
    logic       hit = 1'b0;
    logic [3:0] angle_idx;
    logic [8:0] angle_onehot;
    logic [9:0] aim_dx, aim_dy, bullet_dx, bullet_dy;
    logic       bullet_active, launch, busy;

    int checks = 0;
    int errors = 0;

    turret_fire_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode), .hit(hit),
        .angle_idx(angle_idx), .angle_onehot(angle_onehot), .aim_dx(aim_dx), .aim_dy(aim_dy),
        .bullet_dx(bullet_dx), .bullet_dy(bullet_dy), .bullet_active(bullet_active),
        .launch(launch), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // One tick cycle with the given keycode; returns 1 time unit after the sampling edge.
    task automatic tick_key(input logic [7:0] k);
        keycode = k;
        frame_tick = 1'b1;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        idle_cycles(2);
        checks++;
        if (angle_idx !== 4'd4 || angle_onehot !== 9'h010 || aim_dx !== 10'd1 || aim_dy !== 10'd0) begin
            errors++;
            $display("FAIL reset_angle: idx=%0d onehot=%h aim=(%h,%h) want 4 010 (001,000)",
                     angle_idx, angle_onehot, aim_dx, aim_dy);
        end
        checks++;
        if (bullet_dx !== 10'd0 || bullet_dy !== 10'd0 || bullet_active !== 1'b0 || launch !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_bullet: b=(%h,%h) active=%b launch=%b busy=%b want all 0",
                     bullet_dx, bullet_dy, bullet_active, launch, busy);
        end
        Reset = 1'b1;
        idle_cycles(1);
        for (int i = 0; i < 10; i++) begin
            tick_key(8'd0);
            checks++;
            if (launch !== 1'b0 || bullet_active !== 1'b0 || angle_idx !== 4'd4) begin
                errors++;
                $display("FAIL idle_tick%0d: launch=%b active=%b idx=%0d want 0 0 4", i, launch, bullet_active, angle_idx);
            end
        end
        $display("reset: idx=%0d aim=(%h,%h)", angle_idx, aim_dx, aim_dy);
    endtask

    task automatic test_rotate;
        int exp_idx;
        exp_idx = 4;
        for (int i = 0; i < 6; i++) begin
            tick_key(8'h1A);
            exp_idx = (exp_idx < 8) ? exp_idx + 1 : 8;
            checks++;
            if (angle_idx !== 4'(exp_idx) || angle_onehot !== (9'd1 << exp_idx)) begin
                errors++;
                $display("FAIL rot_up%0d: idx=%0d onehot=%h want %0d", i, angle_idx, angle_onehot, exp_idx);
            end
            tick_key(8'd0);
        end
        checks++;
        if (aim_dx !== 10'd0 || aim_dy !== 10'h3FF) begin
            errors++;
            $display("FAIL aim_idx8: aim=(%h,%h) want (000,3ff)", aim_dx, aim_dy);
        end
        for (int i = 0; i < 9; i++) begin
            tick_key(8'h16);
            exp_idx = (exp_idx > 0) ? exp_idx - 1 : 0;
            checks++;
            if (angle_idx !== 4'(exp_idx)) begin
                errors++;
                $display("FAIL rot_down%0d: idx=%0d want %0d", i, angle_idx, exp_idx);
            end
            tick_key(8'd0);
        end
        checks++;
        if (aim_dx !== 10'd0 || aim_dy !== 10'd1 || angle_onehot !== 9'h001) begin
            errors++;
            $display("FAIL aim_idx0: aim=(%h,%h) onehot=%h want (000,001) 001", aim_dx, aim_dy, angle_onehot);
        end
        $display("rotate: idx=%0d aim=(%h,%h)", angle_idx, aim_dx, aim_dy);
    endtask

    task automatic test_flight;
        for (int i = 0; i < 7; i++) begin
            tick_key(8'h1A);
            tick_key(8'd0);
        end
        checks++;
        if (angle_idx !== 4'd7 || aim_dx !== 10'd1 || aim_dy !== 10'h3FE) begin
            errors++;
            $display("FAIL aim_idx7: idx=%0d aim=(%h,%h) want 7 (001,3fe)", angle_idx, aim_dx, aim_dy);
        end
        tick_key(8'h2C);
        checks++;
        if (launch !== 1'b1 || bullet_active !== 1'b1 || busy !== 1'b1 || bullet_dx !== 10'd1 || bullet_dy !== 10'h3FE) begin
            errors++;
            $display("FAIL launch7: launch=%b active=%b busy=%b b=(%h,%h) want 1 1 1 (001,3fe)",
                     launch, bullet_active, busy, bullet_dx, bullet_dy);
        end
        idle_cycles(1);
        checks++;
        if (launch !== 1'b0) begin
            errors++;
            $display("FAIL launch_pulse: launch=%b want 0", launch);
        end
        for (int i = 1; i <= 120; i++) begin
            tick_key((i == 2 || i == 4) ? 8'h16 : 8'd0);
            checks++;
            if (bullet_active !== (i < 120) || busy !== 1'b1) begin
                errors++;
                $display("FAIL fly_tick%0d: active=%b busy=%b want %b 1", i, bullet_active, busy, (i < 120));
            end
            if (i == 5) begin
                checks++;
                if (angle_idx !== 4'd5 || bullet_dx !== 10'd1 || bullet_dy !== 10'h3FE) begin
                    errors++;
                    $display("FAIL fly_rotate: idx=%0d b=(%h,%h) want 5 (001,3fe)", angle_idx, bullet_dx, bullet_dy);
                end
            end
        end
        for (int j = 1; j <= 30; j++) begin
            tick_key(8'd0);
            checks++;
            if (busy !== (j < 30) || bullet_active !== 1'b0) begin
                errors++;
                $display("FAIL cool_tick%0d: busy=%b active=%b want %b 0", j, busy, bullet_active, (j < 30));
            end
        end
        checks++;
        if (bullet_dx !== 10'd1 || bullet_dy !== 10'h3FE) begin
            errors++;
            $display("FAIL bullet_hold: b=(%h,%h) want (001,3fe)", bullet_dx, bullet_dy);
        end
        $display("flight: idx=%0d bullet=(%h,%h) busy=%b", angle_idx, bullet_dx, bullet_dy, busy);
    endtask

    task automatic test_fire_held;
        int relaunches;
        relaunches = 0;
        tick_key(8'h2C);
        checks++;
        if (launch !== 1'b1) begin
            errors++;
            $display("FAIL held_first: launch=%b want 1", launch);
        end
        for (int i = 0; i < 160; i++) begin
            tick_key(8'h2C);
            if (launch === 1'b1) relaunches++;
        end
        checks++;
        if (relaunches !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_relaunch: relaunches=%0d busy=%b want 0 0", relaunches, busy);
        end
        tick_key(8'd0);
        tick_key(8'h2C);
        checks++;
        if (launch !== 1'b1 || bullet_active !== 1'b1) begin
            errors++;
            $display("FAIL repress_launch: launch=%b active=%b want 1 1", launch, bullet_active);
        end
        $display("fire_held: relaunches=%0d", relaunches);
    endtask

    task automatic test_reset_midflight;
        tick_key(8'd0);
        idle_cycles(1);
        Reset = 1'b0;
        #2;
        checks++;
        if (bullet_active !== 1'b0 || busy !== 1'b0 || bullet_dx !== 10'd0 || bullet_dy !== 10'd0 || angle_idx !== 4'd4) begin
            errors++;
            $display("FAIL midflight_reset: active=%b busy=%b b=(%h,%h) idx=%0d want 0 0 (000,000) 4",
                     bullet_active, busy, bullet_dx, bullet_dy, angle_idx);
        end
        idle_cycles(2);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle_cycles(1);
            checks++;
            if (launch !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL release_launch%0d: launch=%b busy=%b want 0 0", i, launch, busy);
            end
        end
        $display("reset_midflight: idx=%0d busy=%b", angle_idx, busy);
    endtask

    task automatic test_hit;
        tick_key(8'h2C);
        checks++;
        if (launch !== 1'b1 || bullet_dx !== 10'd1 || bullet_dy !== 10'd0) begin
            errors++;
            $display("FAIL hit_launch: launch=%b b=(%h,%h) want 1 (001,000)", launch, bullet_dx, bullet_dy);
        end
        for (int i = 0; i < 5; i++) tick_key(8'd0);
        hit = 1'b1;
        idle_cycles(1);
        hit = 1'b0;
        checks++;
        if (bullet_active !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hit_cool: active=%b busy=%b want 0 1", bullet_active, busy);
        end
        for (int j = 1; j <= 30; j++) begin
            tick_key((j == 1) ? 8'h2C : 8'd0);
            checks++;
            if (launch !== 1'b0 || busy !== (j < 30)) begin
                errors++;
                $display("FAIL hit_cool_tick%0d: launch=%b busy=%b want 0 %b", j, launch, busy, (j < 30));
            end
        end
        tick_key(8'h2C);
        checks++;
        if (launch !== 1'b1) begin
            errors++;
            $display("FAIL post_cool_launch: launch=%b want 1", launch);
        end
        for (int i = 1; i < 120; i++) tick_key(8'd0);
        hit = 1'b1;
        tick_key(8'd0);
        hit = 1'b0;
        checks++;
        if (bullet_active !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hit_expire: active=%b busy=%b want 0 1", bullet_active, busy);
        end
        for (int j = 1; j < 30; j++) tick_key(8'd0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hit_expire_cool29: busy=%b want 1", busy);
        end
        tick_key(8'd0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_expire_cool30: busy=%b want 0", busy);
        end
        $display("hit: busy=%b active=%b", busy, bullet_active);
    endtask

    task automatic test_autorepeat;
        logic [3:0] exp_final;
`ifdef TURRET_AUTOREPEAT_EN
        exp_final = 4'd7;
`else
        exp_final = 4'd5;
`endif
        tick_key(8'd0);
        tick_key(8'h1A);
        checks++;
        if (angle_idx !== 4'd5) begin
            errors++;
            $display("FAIL hold_first: idx=%0d want 5", angle_idx);
        end
        for (int i = 2; i <= 20; i++) tick_key(8'h1A);
        checks++;
        if (angle_idx !== exp_final) begin
            errors++;
            $display("FAIL hold_20: idx=%0d want %0d", angle_idx, exp_final);
        end
        tick_key(8'd0);
        $display("autorepeat: idx=%0d", angle_idx);
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_flight();
        test_fire_held();
        test_reset_midflight();
        test_hit();
        test_autorepeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
